// File: rtl/bitstream_mem_writer_pkg.sv
// Shared types and helpers for the bitstream memory writer: write FSM states,
// size-field patch encodings and the byte-lane window a patch occupies.
package bitstream_mem_writer_pkg;

  localparam int BUF_BYTES_DEFAULT = 32;

  localparam logic [31:0] PATCH_SIZE1 = 32'd1;
  localparam logic [31:0] PATCH_SIZE2 = 32'd2;
  localparam logic [31:0] PATCH_SIZE4 = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM_WR,
    PATCH_WR0,
    PATCH_WR1
  } wr_state_t;

  // Two consecutive memory words seen as eight byte lanes.
  typedef struct packed {
    logic [7:0]  be;
    logic [63:0] data;
  } patch_win_t;

  function automatic logic patch_size_legal(input logic [31:0] size);
    return (size == PATCH_SIZE1) || (size == PATCH_SIZE2) || (size == PATCH_SIZE4);
  endfunction

  // Most significant patched byte lands on the lowest byte address.
  function automatic patch_win_t patch_window(input logic [1:0]  lane0,
                                              input logic [2:0]  size,
                                              input logic [31:0] val);
    patch_win_t win;
    logic [2:0] lane;
    logic [1:0] src;
    win = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < size) begin
        lane = 3'(lane0) + 3'(j);
        src  = 2'(size - 3'(j) - 3'd1);
        win.be[lane] = 1'b1;
        win.data[8*lane +: 8] = val[8*src +: 8];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/bitstream_mem_writer_byte_accumulator.sv
// Circular byte staging buffer: accepts 0..8 stream bytes per cycle, exposes the
// oldest four bytes, and releases 0..4 bytes per cycle.
module byte_accumulator #(
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [3:0]               push_cnt,
  input  logic [63:0]              push_data,
  input  logic [2:0]               pop_cnt,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [31:0]              peek_data,
  output logic                     push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   fill_reg;
  logic [AW+1:0] fill_after_push;
  logic          push_ok;

  // A push that does not fit entirely is discarded as a whole.
  assign fill_after_push = {1'b0, fill_reg} + (AW+2)'(push_cnt);
  assign push_ok   = (push_cnt != 4'd0) && (fill_after_push <= (AW+2)'(DEPTH));
  assign push_drop = (push_cnt != 4'd0) && !push_ok;
  assign fill      = fill_reg;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < push_cnt) begin
          mem[wr_ptr_reg + AW'(k)] <= push_data[63-8*k -: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
      end
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_cnt);
      fill_reg   <= fill_reg + (push_ok ? (AW+1)'(push_cnt) : '0) - (AW+1)'(pop_cnt);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_peek
      assign peek_data[8*gi +: 8] = mem[rd_ptr_reg + AW'(gi)];
    end
  endgenerate

endmodule

// File: rtl/bitstream_mem_writer.sv
// Packs the set_bit byte stream into 32-bit frame-buffer words and applies
// header size-field patches once the bytes they overwrite are committed.
module bitstream_mem_writer
  import bitstream_mem_writer_pkg::*;
#(
  parameter int          BUF_BYTES = BUF_BYTES_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  in_byte_cnt,
  input  logic [63:0] in_val,
  input  logic [31:0] patch_offset,
  input  logic [31:0] patch_val,
  input  logic [31:0] patch_size,
  input  logic        flush,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] bytes_committed,
  output logic        done,
  output logic        overflow,
  output logic        patch_overflow
);

  localparam int FW = $clog2(BUF_BYTES) + 1;

  wr_state_t   state_reg, state_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic [2:0]  wr_cnt_reg, wr_cnt_next;
  logic [31:0] committed_reg, committed_eff;
  logic        done_reg, done_next;
  logic        flush_req_reg, flush_req_next;
  logic        pend_valid_reg;
  logic [31:0] pend_offset_reg;
  logic [31:0] pend_val_reg;
  logic [2:0]  pend_size_reg;
  logic        overflow_reg;
  logic        patch_ovf_reg;

  logic [FW-1:0] fill;
  logic [31:0]   peek_data;
  logic [31:0]   partial_data;
  logic [3:0]    partial_be;
  logic [2:0]    pop_cnt;
  logic          acc_drop;
  logic          accept, fill_ge4, partial_ok, eligible;
  logic          port_free, allow_patch, pend_clear;
  logic [32:0]   patch_end;
  patch_win_t    win0;

  byte_accumulator #(.DEPTH(BUF_BYTES)) u_acc (
    .clock     (clock),
    .reset_n   (reset_n),
    .push_cnt  (in_byte_cnt),
    .push_data (in_val),
    .pop_cnt   (pop_cnt),
    .fill      (fill),
    .peek_data (peek_data),
    .push_drop (acc_drop)
  );

  assign accept        = mem_we_reg && mem_ready;
  assign committed_eff = committed_reg + (accept ? {29'd0, wr_cnt_reg} : 32'd0);
  assign patch_end     = {1'b0, pend_offset_reg} + {30'd0, pend_size_reg};
  assign eligible      = pend_valid_reg && (patch_end <= {1'b0, committed_reg});
  assign win0          = patch_window(pend_offset_reg[1:0], pend_size_reg, pend_val_reg);
  assign fill_ge4      = fill >= FW'(4);
  assign partial_ok    = flush_req_reg && (fill != '0) && !fill_ge4 && (in_byte_cnt == 4'd0);
  assign partial_be    = (4'b0001 << fill[1:0]) - 4'b0001;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_partial
      assign partial_data[8*gi +: 8] = partial_be[gi] ? peek_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    wr_cnt_next    = wr_cnt_reg;
    pop_cnt        = 3'd0;
    pend_clear     = 1'b0;
    done_next      = 1'b0;
    flush_req_next = flush_req_reg | flush;
    port_free      = 1'b0;
    allow_patch    = 1'b1;

    unique case (state_reg)
      IDLE:      port_free = 1'b1;
      STREAM_WR: port_free = accept;
      PATCH_WR0: begin
        if (accept) begin
          if (win0.be[7:4] != 4'd0) begin
            state_next     = PATCH_WR1;
            mem_addr_next  = mem_addr_reg + 32'd1;
            mem_wdata_next = win0.data[63:32];
            mem_be_next    = win0.be[7:4];
          end else begin
            pend_clear  = 1'b1;
            port_free   = 1'b1;
            allow_patch = 1'b0;
          end
        end
      end
      PATCH_WR1: begin
        if (accept) begin
          pend_clear  = 1'b1;
          port_free   = 1'b1;
          allow_patch = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Chain the next write straight after an acceptance to sustain one word per cycle.
    if (port_free) begin
      state_next  = IDLE;
      mem_we_next = 1'b0;
      wr_cnt_next = 3'd0;
      if (eligible && allow_patch) begin
        state_next     = PATCH_WR0;
        mem_we_next    = 1'b1;
        mem_addr_next  = BASE_ADDR + {2'b00, pend_offset_reg[31:2]};
        mem_wdata_next = win0.data[31:0];
        mem_be_next    = win0.be[3:0];
      end else if (fill_ge4) begin
        state_next     = STREAM_WR;
        mem_we_next    = 1'b1;
        mem_addr_next  = BASE_ADDR + {2'b00, committed_eff[31:2]};
        mem_wdata_next = peek_data;
        mem_be_next    = 4'hF;
        wr_cnt_next    = 3'd4;
        pop_cnt        = 3'd4;
      end else if (partial_ok) begin
        state_next     = STREAM_WR;
        mem_we_next    = 1'b1;
        mem_addr_next  = BASE_ADDR + {2'b00, committed_eff[31:2]};
        mem_wdata_next = partial_data;
        mem_be_next    = partial_be;
        wr_cnt_next    = fill[2:0];
        pop_cnt        = fill[2:0];
      end else if ((state_reg == IDLE) && flush_req_reg && (fill == '0) &&
                   !pend_valid_reg && (in_byte_cnt == 4'd0)) begin
        done_next      = 1'b1;
        flush_req_next = flush;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      wr_cnt_reg    <= '0;
      committed_reg <= '0;
      done_reg      <= 1'b0;
      flush_req_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      wr_cnt_reg    <= wr_cnt_next;
      committed_reg <= committed_eff;
      done_reg      <= done_next;
      flush_req_reg <= flush_req_next;
    end
  end

  // Single pending patch; a second legal patch while one waits is refused.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_reg  <= 1'b0;
      pend_offset_reg <= '0;
      pend_val_reg    <= '0;
      pend_size_reg   <= '0;
      overflow_reg    <= 1'b0;
      patch_ovf_reg   <= 1'b0;
    end else begin
      if (pend_clear) begin
        pend_valid_reg <= 1'b0;
      end
      if (patch_size_legal(patch_size)) begin
        if (pend_valid_reg) begin
          patch_ovf_reg <= 1'b1;
        end else begin
          pend_valid_reg  <= 1'b1;
          pend_offset_reg <= patch_offset;
          pend_val_reg    <= patch_val;
          pend_size_reg   <= patch_size[2:0];
        end
      end
      if (acc_drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign mem_we          = mem_we_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wdata       = mem_wdata_reg;
  assign mem_be          = mem_be_reg;
  assign bytes_committed = committed_reg;
  assign done            = done_reg;
  assign overflow        = overflow_reg;
  assign patch_overflow  = patch_ovf_reg;

endmodule

// File: tb/tb_bitstream_mem_writer.sv
// Scoreboard bench for bitstream_mem_writer: stimulus queues expected memory
// writes from a byte-level model; a monitor pops and compares each accepted write.
module tb_bitstream_mem_writer;

  localparam int BUF = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_byte_cnt = '0;
  logic [63:0] in_val = '0;
  logic [31:0] patch_offset = '0;
  logic [31:0] patch_val = '0;
  logic [31:0] patch_size = '0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] bytes_committed;
  logic        done;
  logic        overflow;
  logic        patch_overflow;

  always #5 clock = ~clock;

  bitstream_mem_writer #(.BUF_BYTES(BUF), .BASE_ADDR(32'd0)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_byte_cnt     (in_byte_cnt),
    .in_val          (in_val),
    .patch_offset    (patch_offset),
    .patch_val       (patch_val),
    .patch_size      (patch_size),
    .flush           (flush),
    .mem_we          (mem_we),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .bytes_committed (bytes_committed),
    .done            (done),
    .overflow        (overflow),
    .patch_overflow  (patch_overflow)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned tot = 0;
  logic [31:0] cur_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Byte n of the stream goes to word n/4, lane n%4.
  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    cur_word[8*(tot%4) +: 8] = b;
    if (tot % 4 == 3) begin
      w.addr = tot / 4;
      w.data = cur_word;
      w.be   = 4'hF;
      exp_q.push_back(w);
      cur_word = '0;
    end
    tot++;
  endtask

  task automatic model_flush();
    wr_t w;
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < int'(tot % 4); i++) be[i] = 1'b1;
    if (tot % 4 != 0) begin
      w.addr = tot / 4;
      w.data = cur_word;
      w.be   = be;
      exp_q.push_back(w);
    end
  endtask

  task automatic model_patch(input int unsigned off, input int size, input logic [31:0] val);
    wr_t w[2];
    int unsigned base, a, k;
    base = off / 4;
    for (int i = 0; i < 2; i++) begin
      w[i].addr = base + i;
      w[i].data = '0;
      w[i].be   = '0;
    end
    for (int j = 0; j < size; j++) begin
      a = off + j;
      k = a / 4 - base;
      w[k].data[8*(a%4) +: 8] = val[8*(size-1-j) +: 8];
      w[k].be[a%4] = 1'b1;
    end
    exp_q.push_back(w[0]);
    if (w[1].be != 4'd0) exp_q.push_back(w[1]);
  endtask

  task automatic push(input int cnt, input logic [63:0] val);
    in_byte_cnt = 4'(cnt);
    in_val      = val;
    for (int k = 0; k < cnt; k++) model_byte(val[63-8*k -: 8]);
    tick();
    in_byte_cnt = '0;
    in_val      = '0;
  endtask

  task automatic issue_patch(input logic [31:0] off, input logic [31:0] size, input logic [31:0] val);
    patch_offset = off;
    patch_size   = size;
    patch_val    = val;
    tick();
    patch_size   = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_byte_cnt = '0;
    flush = 1'b0;
    patch_size = '0;
    exp_q.delete();
    tot = 0;
    cur_word = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic wait_committed(input string name, input int unsigned n);
    for (int i = 0; i < 300 && bytes_committed < n; i++) tick();
    check(name, bytes_committed, n);
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    check(name, seen, 1);
    @(negedge clock);
    check({name, "_single"}, done, 0);
    tick();
  endtask

  // Monitor: every accepted write must match the next expected one; a stalled
  // write must keep its address, data and enables.
  initial begin
    wr_t         w;
    logic        held_valid;
    logic [67:0] held;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        held_valid = 1'b0;
      end else begin
        if (mem_we && held_valid) check("hold_stable", {mem_addr, mem_wdata, mem_be}, held);
        if (mem_we && mem_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {mem_addr, mem_wdata, mem_be}, 68'd0);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", mem_addr, w.addr);
            check("wr_data", mem_wdata, w.data);
            check("wr_be", mem_be, w.be);
          end
          held_valid = 1'b0;
        end else if (mem_we) begin
          held = {mem_addr, mem_wdata, mem_be};
          held_valid = 1'b1;
        end else begin
          held_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned off, sz, cnt;
    logic [31:0] v;
    int sizes[3];
    sizes = '{1, 2, 4};

    do_reset();
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_committed", bytes_committed, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_patch_ovf", patch_overflow, 0);

    // Two full words from one 8-byte push.
    mem_ready = 1'b1;
    push(8, 64'h0001020304050607);
    wait_empty("drain_8bytes");
    check("committed_8", bytes_committed, 8);

    // Partial word at flush, then done.
    do_reset();
    push(5, 64'hAABBCCDDEE000000);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    wait_done("done_flush5");
    wait_empty("drain_flush5");
    check("committed_5", bytes_committed, 5);

    // Stall for three cycles with a write pending.
    do_reset();
    mem_ready = 1'b0;
    push(4, {$urandom, $urandom});
    for (int i = 0; i < 10 && !mem_we; i++) tick();
    check("stall_we_seen", mem_we, 1);
    repeat (3) tick();
    check("stall_we_still", mem_we, 1);
    mem_ready = 1'b1;
    wait_empty("drain_stall");

    // Patches over 16 committed bytes.
    do_reset();
    push(8, {$urandom, $urandom});
    push(8, {$urandom, $urandom});
    wait_committed("committed_16", 16);
    wait_empty("drain_16");
    issue_patch(32'd2, 32'd4, 32'h11223344);
    model_patch(2, 4, 32'h11223344);
    wait_empty("patch_span");
    for (int i = 0; i < 8; i++) begin
      sz  = sizes[$urandom_range(0, 2)];
      off = $urandom_range(0, 16 - sz);
      v   = $urandom;
      issue_patch(off, sz, v);
      model_patch(off, sz, v);
      wait_empty("patch_rand");
    end
    issue_patch(32'd0, 32'd3, 32'hDEADBEEF);
    repeat (4) tick();
    check("illegal_patch_ignored", exp_q.size(), 0);

    // Held patch waits for its bytes; a second patch is refused.
    do_reset();
    push(8, {$urandom, $urandom});
    wait_committed("committed_8b", 8);
    wait_empty("drain_8b");
    v = $urandom;
    issue_patch(32'd20, 32'd2, v);
    check("patch_ovf_clear", patch_overflow, 0);
    issue_patch(32'd0, 32'd1, 32'h55);
    check("patch_ovf_set", patch_overflow, 1);
    push(8, {$urandom, $urandom});
    push(8, {$urandom, $urandom});
    // The held patch lands only after the words completing bytes 20..21.
    model_patch(20, 2, v);
    wait_empty("held_patch");
    check("committed_24", bytes_committed, 24);

    // Random stream with random back-pressure.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      mem_ready = ($urandom_range(0, 9) < 7);
      cnt = $urandom_range(0, 8);
      if (tot - bytes_committed + cnt > BUF) cnt = 0;
      push(cnt, {$urandom, $urandom});
    end
    mem_ready = 1'b1;
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    wait_done("done_random");
    wait_empty("drain_random");
    check("committed_random", bytes_committed, tot);
    check("no_overflow_random", overflow, 0);

    // Overflow with memory stalled, then reset in the middle of a write.
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8, {$urandom, $urandom});
    check("overflow_after4", overflow, 0);
    push(8, {$urandom, $urandom});
    check("overflow_after5", overflow, 1);
    check("midwrite_we", mem_we, 1);
    reset_n = 1'b0;
    #2;
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_be", mem_be, 0);
    check("arst_committed", bytes_committed, 0);
    check("arst_overflow", overflow, 0);
    check("arst_patch_ovf", patch_overflow, 0);
    check("arst_done", done, 0);
    mem_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    check("post_reset_idle", mem_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
